controlador_jugadas: RTL and testbench
======================================

Name: controlador_jugadas

Overview:
- Turn sequencer for the Connect-4 board.
- Owns the 6x7 board register and arbitrates column requests between the human player and the random-move timer pulses.
- Performs the gravity drop, one row per cycle, then handshakes with an external win checker before alternating players.
- Drives the timer's enable and movimiento_hecho inputs, and supplies the board to the timer and to the VGA renderer.

Parameters:
- FILAS, 6, board rows; row 0 is the top row.
- COLUMNAS, 7, board columns.
- JUGADOR_INICIAL, 2'b01, player code that moves first after iniciar.

Ports:
- clk  input  1  system clock (25.175 MHz pixel clock domain).
- reset  input  1  asynchronous, active-low reset.
- iniciar  input  1  start/restart pulse.
- col_jugador  input  7  one-hot column request from player input, one-cycle pulse.
- pulsos_random  input  7  one-hot column pulse from the random-move timer.
- verif_listo  input  1  win checker done strobe.
- hay_ganador  input  1  win checker result; valid while verif_listo=1.
- tablero  output  2x[5:0][6:0]  board cells: 00 empty, 01 player 1, 10 player 2.
- jugador_actual  output  2  player whose turn it is.
- enable_timer  output  1  high only in state ESPERA.
- movimiento_hecho  output  1  one-cycle pulse on each piece placement.
- verificar  output  1  one-cycle pulse requesting a win check.
- ultima_fila  output  3  row of the last placed piece.
- ultima_col  output  3  column of the last placed piece.
- jugada_invalida  output  1  one-cycle pulse when a request is rejected.
- ganador  output  2  winning player code; 00 if none.
- empate  output  1  draw flag.
- estado  output  3  current FSM state encoding, for debug/LEDs.

Behaviour:
- Reset (reset=0, asynchronous):
  - State IDLE; all board cells 00.
  - jugador_actual=JUGADOR_INICIAL.
  - All pulse outputs 0; enable_timer=0.
  - ultima_fila=0, ultima_col=0, ganador=00, empate=0.
  - Reset asserted mid-drop or mid-check aborts with no partial write.
- States: IDLE, ESPERA, BUSCAR, COLOCAR, VERIFICAR, FIN.
- IDLE / FIN on iniciar=1:
  - Clear board, ganador and empate in one edge.
  - jugador_actual=JUGADOR_INICIAL; go to ESPERA.
  - iniciar in any other state is ignored.
- ESPERA, request arbitration:
  - Request source is col_jugador if it is nonzero, else pulsos_random. The player wins when both are nonzero in the same cycle.
  - A request vector with more than one bit set, or bit 7 position unused, is rejected: jugada_invalida pulses, state stays ESPERA.
  - A request for a full column (tablero[0][c]!=00) is rejected the same way.
  - A valid request latches column c, sets the row pointer to FILAS-1 and goes to BUSCAR.
  - Requests arriving outside ESPERA are dropped silently.
- BUSCAR:
  - Each cycle, if tablero[fila][c]==00, go to COLOCAR; else decrement fila.
  - Termination is guaranteed because row 0 was checked empty.
- COLOCAR:
  - On the exit edge, write jugador_actual into tablero[fila][c] and load ultima_fila/ultima_col.
  - On the same edge, movimiento_hecho=1 and verificar=1 for exactly one cycle; go to VERIFICAR.
- Latency: from the edge sampling the request to board write visible = 2 + (number of occupied cells in column c) cycles.
- VERIFICAR:
  - Wait indefinitely for verif_listo=1.
  - If hay_ganador=1: ganador<=jugador_actual; go to FIN.
  - Else toggle jugador_actual (01<->10) and return to ESPERA.
  - verif_listo outside VERIFICAR is ignored.
- enable_timer=1 exactly while in ESPERA. It drops for at least one cycle on every move, so the timer restarts its 10 s count.
- FIN: board frozen; enable_timer=0; waits for iniciar.

Optional Feature:
- Macro: CONTROL_EMPATE_EN.
- Defined:
  - A 6-bit piece counter is cleared on reset and on iniciar, and increments on each COLOCAR.
  - In VERIFICAR with hay_ganador=0 and the counter at 42: set empate=1, keep ganador=00, go to FIN.
  - A win on the 42nd piece takes priority over the draw.
- Undefined:
  - No counter; empate tied to 0.
  - A full board leaves the FSM in ESPERA; every request is rejected with jugada_invalida.

Test Plan:
- Empty board after iniciar; col_jugador=0001000 -> 2 cycles later tablero[5][3]=01, movimiento_hecho and verificar pulse once, ultima_fila=5, ultima_col=3; verif_listo=1 with hay_ganador=0 -> jugador_actual=10, enable_timer=1.
- Column 0 holding 3 pieces; pulsos_random=0000001 -> write at row 2 after 5 cycles, jugador_actual code written.
- col_jugador=0000100 and pulsos_random=1000000 in the same cycle -> column 2 placed, column 6 unchanged.
- Full column 4 requested, and col_jugador=0000011 -> jugada_invalida pulses each time, state ESPERA, board unchanged.
- hay_ganador=1 on verif_listo -> ganador=current player, FIN; requests ignored; iniciar -> board cleared, ESPERA, jugador_actual=01.
- reset low during BUSCAR -> board cleared immediately, IDLE, no movimiento_hecho; with CONTROL_EMPATE_EN, 42 non-winning moves -> empate=1, FIN.

Source files
------------

// File: rtl/controlador_jugadas.sv
// Connect-4 turn sequencer: board register, column arbitration, gravity drop and win-check handshake.
// Optional draw detection is compiled in with `define CONTROL_EMPATE_EN.
module controlador_jugadas #(
  parameter int         FILAS           = 6,
  parameter int         COLUMNAS        = 7,
  parameter logic [1:0] JUGADOR_INICIAL = 2'b01
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 iniciar,
  input  logic [COLUMNAS-1:0]                  col_jugador,
  input  logic [COLUMNAS-1:0]                  pulsos_random,
  input  logic                                 verif_listo,
  input  logic                                 hay_ganador,
  output logic [FILAS-1:0][COLUMNAS-1:0][1:0]  tablero,
  output logic [1:0]                           jugador_actual,
  output logic                                 enable_timer,
  output logic                                 movimiento_hecho,
  output logic                                 verificar,
  output logic [2:0]                           ultima_fila,
  output logic [2:0]                           ultima_col,
  output logic                                 jugada_invalida,
  output logic [1:0]                           ganador,
  output logic                                 empate,
  output logic [2:0]                           estado
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ESPERA    = 3'd1,
    BUSCAR    = 3'd2,
    COLOCAR   = 3'd3,
    VERIFICAR = 3'd4,
    FIN       = 3'd5
  } estado_t;

  estado_t                             estado_q, estado_d;
  logic [FILAS-1:0][COLUMNAS-1:0][1:0] tablero_q, tablero_d;
  logic [1:0]                          jugador_q, jugador_d;
  logic [2:0]                          fila_q, fila_d;
  logic [2:0]                          col_q, col_d;
  logic [2:0]                          ufila_q, ufila_d;
  logic [2:0]                          ucol_q, ucol_d;
  logic [1:0]                          ganador_q, ganador_d;
  logic                                mov_q, mov_d;
  logic                                verif_q, verif_d;
  logic                                inval_q, inval_d;
`ifdef CONTROL_EMPATE_EN
  logic [5:0]                          cnt_q, cnt_d;
  logic                                empate_q, empate_d;
`endif

  logic [COLUMNAS-1:0] req;
  logic [2:0]          req_idx;
  logic                req_llena;

  always_comb begin
    req     = (|col_jugador) ? col_jugador : pulsos_random;
    req_idx = 3'd0;
    for (int i = 0; i < COLUMNAS; i++) begin
      if (req[i]) req_idx = 3'(i);
    end
    req_llena = (tablero_q[0][req_idx] != 2'b00);
  end

  always_comb begin
    estado_d  = estado_q;
    tablero_d = tablero_q;
    jugador_d = jugador_q;
    fila_d    = fila_q;
    col_d     = col_q;
    ufila_d   = ufila_q;
    ucol_d    = ucol_q;
    ganador_d = ganador_q;
    mov_d     = 1'b0;
    verif_d   = 1'b0;
    inval_d   = 1'b0;
`ifdef CONTROL_EMPATE_EN
    cnt_d     = cnt_q;
    empate_d  = empate_q;
`endif
    case (estado_q)
      IDLE, FIN: begin
        if (iniciar) begin
          tablero_d = '0;
          ganador_d = 2'b00;
          jugador_d = JUGADOR_INICIAL;
`ifdef CONTROL_EMPATE_EN
          cnt_d     = 6'd0;
          empate_d  = 1'b0;
`endif
          estado_d  = ESPERA;
        end
      end
      ESPERA: begin
        if (|req) begin
          if (!$onehot(req) || req_llena) begin
            inval_d = 1'b1;
          end else begin
            col_d    = req_idx;
            fila_d   = 3'(FILAS - 1);
            estado_d = BUSCAR;
          end
        end
      end
      BUSCAR: begin
        // Row 0 was checked empty on acceptance, so this walk always stops.
        if (tablero_q[fila_q][col_q] == 2'b00) estado_d = COLOCAR;
        else                                   fila_d   = fila_q - 3'd1;
      end
      COLOCAR: begin
        tablero_d[fila_q][col_q] = jugador_q;
        ufila_d  = fila_q;
        ucol_d   = col_q;
        mov_d    = 1'b1;
        verif_d  = 1'b1;
`ifdef CONTROL_EMPATE_EN
        cnt_d    = cnt_q + 6'd1;
`endif
        estado_d = VERIFICAR;
      end
      VERIFICAR: begin
        if (verif_listo) begin
          if (hay_ganador) begin
            ganador_d = jugador_q;
            estado_d  = FIN;
`ifdef CONTROL_EMPATE_EN
          end else if (cnt_q == 6'd42) begin
            empate_d  = 1'b1;
            estado_d  = FIN;
`endif
          end else begin
            jugador_d = (jugador_q == 2'b01) ? 2'b10 : 2'b01;
            estado_d  = ESPERA;
          end
        end
      end
      default: estado_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado_q  <= IDLE;
      tablero_q <= '0;
      jugador_q <= JUGADOR_INICIAL;
      fila_q    <= 3'd0;
      col_q     <= 3'd0;
      ufila_q   <= 3'd0;
      ucol_q    <= 3'd0;
      ganador_q <= 2'b00;
      mov_q     <= 1'b0;
      verif_q   <= 1'b0;
      inval_q   <= 1'b0;
`ifdef CONTROL_EMPATE_EN
      cnt_q     <= 6'd0;
      empate_q  <= 1'b0;
`endif
    end else begin
      estado_q  <= estado_d;
      tablero_q <= tablero_d;
      jugador_q <= jugador_d;
      fila_q    <= fila_d;
      col_q     <= col_d;
      ufila_q   <= ufila_d;
      ucol_q    <= ucol_d;
      ganador_q <= ganador_d;
      mov_q     <= mov_d;
      verif_q   <= verif_d;
      inval_q   <= inval_d;
`ifdef CONTROL_EMPATE_EN
      cnt_q     <= cnt_d;
      empate_q  <= empate_d;
`endif
    end
  end

  assign tablero          = tablero_q;
  assign jugador_actual   = jugador_q;
  assign enable_timer     = (estado_q == ESPERA);
  assign movimiento_hecho = mov_q;
  assign verificar        = verif_q;
  assign ultima_fila      = ufila_q;
  assign ultima_col       = ucol_q;
  assign jugada_invalida  = inval_q;
  assign ganador          = ganador_q;
  assign estado           = estado_q;
`ifdef CONTROL_EMPATE_EN
  assign empate           = empate_q;
`else
  assign empate           = 1'b0;
`endif

endmodule

// File: tb/tb_controlador_jugadas.sv
// Bench for controlador_jugadas: directed moves with a queue of expected placements/rejections
// checked by an independent monitor on the falling clock edge.
module tb_controlador_jugadas;

  logic                       clk = 1'b0;
  logic                       reset;
  logic                       iniciar;
  logic [6:0]                 col_jugador;
  logic [6:0]                 pulsos_random;
  logic                       verif_listo;
  logic                       hay_ganador;
  logic [5:0][6:0][1:0]       tablero;
  logic [1:0]                 jugador_actual;
  logic                       enable_timer;
  logic                       movimiento_hecho;
  logic                       verificar;
  logic [2:0]                 ultima_fila;
  logic [2:0]                 ultima_col;
  logic                       jugada_invalida;
  logic [1:0]                 ganador;
  logic                       empate;
  logic [2:0]                 estado;

  controlador_jugadas dut (
    .clk(clk), .reset(reset), .iniciar(iniciar), .col_jugador(col_jugador),
    .pulsos_random(pulsos_random), .verif_listo(verif_listo), .hay_ganador(hay_ganador),
    .tablero(tablero), .jugador_actual(jugador_actual), .enable_timer(enable_timer),
    .movimiento_hecho(movimiento_hecho), .verificar(verificar), .ultima_fila(ultima_fila),
    .ultima_col(ultima_col), .jugada_invalida(jugada_invalida), .ganador(ganador),
    .empate(empate), .estado(estado)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    bit         inval;
    int         when;
    int         f;
    int         c;
    logic [1:0] j;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: every placement or rejection pulse must match the head of the queue.
  always @(negedge clk) begin
    if (reset === 1'b1 && (movimiento_hecho === 1'b1 || jugada_invalida === 1'b1)) begin
      if (q.size() == 0) begin
        chk("unexpected_pulse", {movimiento_hecho, jugada_invalida}, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("pulse_kind", {movimiento_hecho, jugada_invalida}, e.inval ? 32'd1 : 32'd2);
        chk("pulse_cycle", cyc, e.when);
        if (!e.inval) begin
          chk("ultima_fila", ultima_fila, e.f);
          chk("ultima_col", ultima_col, e.c);
          chk("cell_written", tablero[e.f][e.c], e.j);
          chk("verificar_pulse", verificar, 1);
        end
      end
    end
  end

  // Issue one request; push expected outcome (lat = cycles from sampling edge to write).
  task automatic req(input logic [6:0] cj, input logic [6:0] pr, input bit inval,
                     input int f, input int c, input logic [1:0] j, input int lat);
    exp_t e;
    col_jugador   = cj;
    pulsos_random = pr;
    e.inval = inval;
    e.when  = inval ? cyc + 1 : cyc + 1 + lat;
    e.f = f; e.c = c; e.j = j;
    q.push_back(e);
    @(negedge clk);
    col_jugador   = '0;
    pulsos_random = '0;
  endtask

  task automatic wait_state(input logic [2:0] s, input string nm);
    int k = 0;
    while (estado !== s && k < 30) begin
      @(negedge clk);
      k++;
    end
    chk(nm, estado, s);
  endtask

  task automatic verif(input bit win);
    wait_state(3'd4, "reach_verificar");
    verif_listo = 1'b1;
    hay_ganador = win;
    @(negedge clk);
    verif_listo = 1'b0;
    hay_ganador = 1'b0;
  endtask

  task automatic start();
    iniciar = 1'b1;
    @(negedge clk);
    iniciar = 1'b0;
  endtask

  initial begin
    reset = 1'b0; iniciar = 1'b0; col_jugador = '0; pulsos_random = '0;
    verif_listo = 1'b0; hay_ganador = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_estado", estado, 0);
    chk("rst_board", |tablero, 0);
    chk("rst_jugador", jugador_actual, 2'b01);
    chk("rst_enable", enable_timer, 0);
    chk("rst_pulses", {movimiento_hecho, verificar, jugada_invalida}, 0);
    chk("rst_ultima", {ultima_fila, ultima_col}, 0);
    chk("rst_ganador", ganador, 0);
    chk("rst_empate", empate, 0);
    reset = 1'b1;
    @(negedge clk);

    // Requests in IDLE are dropped
    col_jugador = 7'b0000001;
    @(negedge clk);
    col_jugador = '0;
    chk("idle_ignores_req", estado, 0);

    start();
    chk("start_espera", estado, 1);
    chk("start_enable", enable_timer, 1);

    // First move: player 01 into empty column 3
    req(7'b0001000, 7'd0, 0, 5, 3, 2'b01, 2);
    chk("buscar_state", estado, 2);
    chk("buscar_enable_low", enable_timer, 0);
    verif(0);
    chk("toggle_to_10", jugador_actual, 2'b10);
    chk("back_enable", enable_timer, 1);

    // Column 0 stacked by timer pulses; fourth piece lands on row 2 after 5 cycles
    req(7'd0, 7'b0000001, 0, 5, 0, 2'b10, 2); verif(0);
    req(7'd0, 7'b0000001, 0, 4, 0, 2'b01, 3); verif(0);
    req(7'd0, 7'b0000001, 0, 3, 0, 2'b10, 4); verif(0);
    req(7'd0, 7'b0000001, 0, 2, 0, 2'b01, 5); verif(0);

    // Player beats timer in the same cycle
    req(7'b0000100, 7'b1000000, 0, 5, 2, 2'b10, 2); verif(0);
    chk("col6_untouched", tablero[5][6], 0);

    // Fill column 4 completely
    req(7'b0010000, 7'd0, 0, 5, 4, 2'b01, 2); verif(0);
    req(7'b0010000, 7'd0, 0, 4, 4, 2'b10, 3); verif(0);
    req(7'b0010000, 7'd0, 0, 3, 4, 2'b01, 4); verif(0);
    req(7'b0010000, 7'd0, 0, 2, 4, 2'b10, 5); verif(0);
    req(7'b0010000, 7'd0, 0, 1, 4, 2'b01, 6); verif(0);
    req(7'b0010000, 7'd0, 0, 0, 4, 2'b10, 7); verif(0);

    // Rejections: full column, two bits set, two bits on the timer path
    req(7'b0010000, 7'd0, 1, 0, 0, 2'b00, 0);
    chk("full_col_stays", estado, 1);
    req(7'b0000011, 7'd0, 1, 0, 0, 2'b00, 0);
    chk("multi_bit_stays", estado, 1);
    req(7'd0, 7'b0100010, 1, 0, 0, 2'b00, 0);
    chk("board_top4", tablero[0][4], 2'b10);
    chk("board_col1_empty", tablero[5][1], 0);
    chk("jugador_unchanged", jugador_actual, 2'b01);

    // Win ends the game; requests in FIN dropped; iniciar restarts
    req(7'b0000010, 7'd0, 0, 5, 1, 2'b01, 2);
    verif(1);
    chk("win_ganador", ganador, 2'b01);
    chk("win_fin", estado, 5);
    chk("fin_enable_low", enable_timer, 0);
    col_jugador = 7'b0100000;
    repeat (3) @(negedge clk);
    col_jugador = '0;
    chk("fin_frozen", tablero[5][5], 0);
    start();
    chk("restart_board", |tablero, 0);
    chk("restart_state", estado, 1);
    chk("restart_jugador", jugador_actual, 2'b01);
    chk("restart_ganador", ganador, 0);

    // Reset during the drop aborts with no write
    req(7'b1000000, 7'd0, 0, 5, 6, 2'b01, 2); verif(0);
    col_jugador = 7'b1000000;
    @(negedge clk);
    col_jugador = '0;
    chk("pre_abort_buscar", estado, 2);
    reset = 1'b0;
    #1;
    chk("abort_board", |tablero, 0);
    chk("abort_state", estado, 0);
    chk("abort_jugador", jugador_actual, 2'b01);
    repeat (3) @(negedge clk);
    chk("abort_no_move", movimiento_hecho, 0);
    reset = 1'b1;
    @(negedge clk);

`ifdef CONTROL_EMPATE_EN
    start();
    for (int c = 0; c < 7; c++) begin
      for (int k = 0; k < 6; k++) begin
        logic [6:0] v;
        int n;
        v = 7'd1 << c;
        n = c * 6 + k;
        req(v, 7'd0, 0, 5 - k, c, (n % 2 == 0) ? 2'b01 : 2'b10, 2 + k);
        verif(0);
      end
    end
    chk("draw_empate", empate, 1);
    chk("draw_fin", estado, 5);
    chk("draw_no_ganador", ganador, 0);
`endif

    repeat (4) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

endmodule
